// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the datapath/memory.
// master: the sequencer (drives controls); slave: datapath and memory side.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             alu_zero;
   logic             mem_ready;
   logic             mem_req;
   logic             mem_we;
   logic             iord;
   logic             ir_write;
   logic             mdr_write;
   logic             pc_en;
   logic [1:0]       pc_src;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             reg_write;
   logic [1:0]       reg_dst;
   logic [1:0]       wb_sel;
   logic [CNT_W-1:0] retired;
   logic [1:0]       err;

   modport master (
      input  opcode, funct, alu_zero, mem_ready,
      output mem_req, mem_we, iord, ir_write, mdr_write, pc_en, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, wb_sel,
             retired, err
   );

   modport slave (
      output opcode, funct, alu_zero, mem_ready,
      input  mem_req, mem_we, iord, ir_write, mdr_write, pc_en, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, wb_sel,
             retired, err
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: walks one ALU and one unified memory
// through fetch/decode/execute/memory/writeback, counts retired
// instructions and traps illegal encodings and memory timeouts.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [1:0]        err_q, err_d;
   logic              rdst_rd_q, rdst_rd_d;   // 1: ALU_WB writes rd, 0: rt
   logic              mem_wait;
   logic              funct_ok;

   // Legal R-type functions (add/sub/and/or/slt/jr)
   always_comb begin
      funct_ok = 1'b0;
      case (bus.funct)
         6'b100000, 6'b100010, 6'b100100,
         6'b100101, 6'b101010, 6'b001000: funct_ok = 1'b1;
         default:                         funct_ok = 1'b0;
      endcase
   end

   // Next state, wait counter, error cause and retire count
   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      rdst_rd_d = rdst_rd_q;
      wait_d    = '0;
      retired_d = retired_q;
      mem_wait  = (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR)
                  && !bus.mem_ready;
      case (state_q)
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               6'b000000: begin
                  if (!funct_ok)                  state_d = S_ERR;
                  else if (bus.funct == 6'b001000) state_d = S_JR;
                  else                             state_d = S_EXEC_R;
               end
               6'b001000:            state_d = S_EXEC_I;
               6'b100011, 6'b101011: state_d = S_MEM_ADDR;
               6'b000100, 6'b000101: state_d = S_BRANCH;
               6'b000010:            state_d = S_JUMP;
               6'b000011:            state_d = S_JAL;
               default:              state_d = S_ERR;
            endcase
            if (state_d == S_ERR && err_q == 2'b00) err_d = 2'b01;
         end
         S_EXEC_R: begin
            rdst_rd_d = 1'b1;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            rdst_rd_d = 1'b0;
            state_d   = S_ALU_WB;
         end
         // opcode[3] separates sw (101011) from lw (100011)
         S_MEM_ADDR: state_d = bus.opcode[3] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
         S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
         S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
         S_ERR:      state_d = S_ERR;
         default:    state_d = S_FETCH;
      endcase
      // A ready in the would-be timeout cycle is handled above and never gets here
      if (mem_wait) begin
         if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = S_ERR;
            if (err_q == 2'b00) err_d = 2'b10;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
      if (state_d == S_FETCH && state_q != S_FETCH) retired_d = retired_q + 1'b1;
   end

   // State registers, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         retired_q <= '0;
         err_q     <= 2'b00;
         rdst_rd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         err_q     <= err_d;
         rdst_rd_q <= rdst_rd_d;
      end
   end

   // Control decode from state; everything forced low while reset is held
   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.iord      = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mdr_write = 1'b0;
      bus.pc_en     = 1'b0;
      bus.pc_src    = 2'b00;
      bus.alu_src_a = 1'b0;
      bus.alu_src_b = 2'b00;
      bus.alu_op    = 2'b00;
      bus.reg_write = 1'b0;
      bus.reg_dst   = 2'b00;
      bus.wb_sel    = 2'b00;
      bus.retired   = rst_n ? retired_q : '0;
      bus.err       = rst_n ? err_q : 2'b00;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               bus.mem_req   = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_en     = bus.mem_ready;
            end
            S_DECODE:   bus.alu_src_b = 2'b11;
            S_EXEC_R: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b10;
            end
            S_EXEC_I, S_MEM_ADDR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
            end
            S_ALU_WB: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = rdst_rd_q ? 2'b01 : 2'b00;
            end
            S_MEM_RD: begin
               bus.mem_req   = 1'b1;
               bus.iord      = 1'b1;
               bus.mdr_write = bus.mem_ready;
            end
            S_MEM_WB: begin
               bus.reg_write = 1'b1;
               bus.wb_sel    = 2'b01;
            end
            S_MEM_WR: begin
               bus.mem_req = 1'b1;
               bus.mem_we  = 1'b1;
               bus.iord    = 1'b1;
            end
            S_BRANCH: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b01;
               bus.pc_src    = 2'b01;
               bus.pc_en     = bus.alu_zero ^ bus.opcode[0];
            end
            S_JUMP: begin
               bus.pc_src = 2'b10;
               bus.pc_en  = 1'b1;
            end
            S_JAL: begin
               bus.pc_src    = 2'b10;
               bus.pc_en     = 1'b1;
               bus.reg_write = 1'b1;
               bus.reg_dst   = 2'b10;
               bus.wb_sel    = 2'b10;
            end
            S_JR: begin
               bus.pc_src = 2'b11;
               bus.pc_en  = 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: stimulus pushes the expected control
// vector of each cycle into a queue, a monitor pops and compares it.
module tb_multicycle_ctrl;
   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_en;
      logic [1:0] pc_src;
      logic       src_a;
      logic [1:0] src_b, alu_op;
      logic       reg_write;
      logic [1:0] reg_dst, wb_sel;
      logic [3:0] retired;
      logic [1:0] err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;
   exp_t  exp_q[$];
   string name_q[$];
   logic [5:0] op_r, fn_r;
   logic [3:0] ret;

   multicycle_ctrl_if #(.CNT_W(4)) bus ();

   multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Expected control vector per state, straight from the state table
   function automatic exp_t ex(input string st, input logic q, input logic [3:0] r,
                               input logic [1:0] er);
      exp_t e;
      e = '0;
      e.retired = r;
      e.err     = er;
      case (st)
         "FETCH":    begin e.mem_req = 1; e.src_b = 2'b01; e.ir_write = q; e.pc_en = q; end
         "DECODE":   e.src_b = 2'b11;
         "EXEC_R":   begin e.src_a = 1; e.alu_op = 2'b10; end
         "EXEC_I":   begin e.src_a = 1; e.src_b = 2'b10; end
         "MEM_ADDR": begin e.src_a = 1; e.src_b = 2'b10; end
         "WB_RD":    begin e.reg_write = 1; e.reg_dst = 2'b01; end
         "WB_RT":    e.reg_write = 1;
         "MEM_RD":   begin e.mem_req = 1; e.iord = 1; e.mdr_write = q; end
         "MEM_WB":   begin e.reg_write = 1; e.wb_sel = 2'b01; end
         "MEM_WR":   begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
         "BRANCH":   begin e.src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = q; end
         "JUMP":     begin e.pc_src = 2'b10; e.pc_en = 1; end
         "JAL":      begin e.pc_src = 2'b10; e.pc_en = 1; e.reg_write = 1;
                           e.reg_dst = 2'b10; e.wb_sel = 2'b10; end
         "JR":       begin e.pc_src = 2'b11; e.pc_en = 1; end
         default:    ;
      endcase
      return e;
   endfunction

   task automatic cyc(input logic r, input logic rdy, input logic z, input exp_t e,
                      input string n);
      rst_n         = r;
      bus.mem_ready = rdy;
      bus.alu_zero  = z;
      bus.opcode    = op_r;
      bus.funct     = fn_r;
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   // Zero-wait fetch followed by decode
   task automatic fd(input string n);
      cyc(1, 1, 0, ex("FETCH", 1, ret, 2'b00), {n, "_fetch"});
      cyc(1, 1, 0, ex("DECODE", 0, ret, 2'b00), {n, "_decode"});
   endtask

   task automatic instr3(input logic [5:0] op, input logic [5:0] fn, input string st,
                         input logic z, input logic q, input string n);
      op_r = op; fn_r = fn;
      fd(n);
      cyc(1, 1, z, ex(st, q, ret, 2'b00), {n, "_exec"});
      ret = ret + 1'b1;
   endtask

   // Monitor: compares every queued expectation, owns the summary
   initial begin
      exp_t  a, e;
      string n;
      int    cycles = 0;
      int    idle = 0;
      forever begin
         @(negedge clk);
         cycles++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.mdr_write, bus.pc_en,
                 bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                 bus.reg_dst, bus.wb_sel, bus.retired, bus.err};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h", n, a, e);
            end
         end else if (stim_done) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
         if (stim_done) idle++;
         if (cycles > 2000 || idle > 5) begin
            checks++;
            errors++;
            $display("FAIL watchdog: got %0d cycles expected under 2000", cycles);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.mem_ready = 1'b0; bus.alu_zero = 1'b0; bus.opcode = '0; bus.funct = '0;
      op_r = '0; fn_r = '0; ret = '0;
      @(posedge clk);
      #1;
      cyc(0, 1, 0, ex("ZERO", 0, 0, 2'b00), "reset");

      // add: 4 cycles, writes rd
      op_r = 6'b000000; fn_r = 6'b100000;
      fd("add");
      cyc(1, 1, 0, ex("EXEC_R", 0, ret, 2'b00), "add_exec");
      cyc(1, 1, 0, ex("WB_RD", 0, ret, 2'b00), "add_wb");
      ret = ret + 1'b1;

      // lw with three wait cycles in MEM_RD: 8 cycles
      op_r = 6'b100011; fn_r = 6'b000000;
      fd("lw");
      cyc(1, 1, 0, ex("MEM_ADDR", 0, ret, 2'b00), "lw_addr");
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, ex("MEM_RD", 0, ret, 2'b00), "lw_wait");
      cyc(1, 1, 0, ex("MEM_RD", 1, ret, 2'b00), "lw_rd");
      cyc(1, 1, 0, ex("MEM_WB", 0, ret, 2'b00), "lw_wb");
      ret = ret + 1'b1;

      // sw: 4 cycles
      op_r = 6'b101011;
      fd("sw");
      cyc(1, 1, 0, ex("MEM_ADDR", 0, ret, 2'b00), "sw_addr");
      cyc(1, 1, 0, ex("MEM_WR", 0, ret, 2'b00), "sw_wr");
      ret = ret + 1'b1;

      // addi: 4 cycles, writes rt
      op_r = 6'b001000;
      fd("addi");
      cyc(1, 1, 0, ex("EXEC_I", 0, ret, 2'b00), "addi_exec");
      cyc(1, 1, 0, ex("WB_RT", 0, ret, 2'b00), "addi_wb");
      ret = ret + 1'b1;

      // branches: taken = zero for beq, nonzero for bne
      instr3(6'b000100, 6'b0, "BRANCH", 1, 1, "beq_z1");
      instr3(6'b000101, 6'b0, "BRANCH", 1, 0, "bne_z1");
      instr3(6'b000100, 6'b0, "BRANCH", 0, 0, "beq_z0");
      instr3(6'b000101, 6'b0, "BRANCH", 0, 1, "bne_z0");
      instr3(6'b000010, 6'b0, "JUMP", 0, 0, "j");
      instr3(6'b000011, 6'b0, "JAL", 0, 0, "jal");
      instr3(6'b000000, 6'b001000, "JR", 0, 0, "jr");
      // five more jumps: retired 11 -> 16 wraps to 0
      for (int i = 0; i < 5; i++) instr3(6'b000010, 6'b0, "JUMP", 0, 0, "j_wrap");

      // fetch: ready arrives in the would-be timeout cycle and wins
      op_r = 6'b000010;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, ex("FETCH", 0, ret, 2'b00), "late_wait");
      cyc(1, 1, 0, ex("FETCH", 1, ret, 2'b00), "late_fetch");
      cyc(1, 1, 0, ex("DECODE", 0, ret, 2'b00), "late_decode");
      cyc(1, 1, 0, ex("JUMP", 0, ret, 2'b00), "late_jump");
      ret = ret + 1'b1;

      // illegal R funct
      op_r = 6'b000000; fn_r = 6'b111111;
      fd("badfn");
      for (int i = 0; i < 2; i++) cyc(1, 1, 0, ex("ZERO", 0, ret, 2'b01), "badfn_err");
      cyc(0, 1, 0, ex("ZERO", 0, 0, 2'b00), "badfn_reset");
      ret = '0;

      // illegal opcode: ERR holds 10 cycles with no mem_req, then reset clears
      op_r = 6'b111111; fn_r = 6'b000000;
      fd("badop");
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, ex("ZERO", 0, ret, 2'b01), "badop_err");
      cyc(0, 1, 0, ex("ZERO", 0, 0, 2'b00), "badop_reset");
      ret = '0;

      // memory timeout in FETCH: 4 wait cycles -> ERR, err=10
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, ex("FETCH", 0, ret, 2'b00), "to_wait");
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, ex("ZERO", 0, ret, 2'b10), "to_err");
      cyc(0, 1, 0, ex("ZERO", 0, 0, 2'b00), "to_reset");

      // reset during ALU_WB aborts the write
      op_r = 6'b000000; fn_r = 6'b100000;
      fd("abort");
      cyc(1, 1, 0, ex("EXEC_R", 0, ret, 2'b00), "abort_exec");
      cyc(0, 1, 0, ex("ZERO", 0, 0, 2'b00), "abort_reset");
      cyc(1, 1, 0, ex("FETCH", 1, 0, 2'b00), "abort_fetch");

      stim_done = 1'b1;
   end
endmodule
